// File: rtl/lcd_pkg.sv
// Shared types, command constants and helpers for the LCD write engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;
  // HD44780 ignores bit 0 of the home command, so 0x03 is also a home.
  localparam logic [7:0] HOME_ALT = 8'h03;

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CLEAR) || (b == HOME) || (b == HOME_ALT));
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with zero flag; times every engine phase.
module lcd_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780-class LCD bus write engine with setup/pulse/hold/busy-wait timing.
// Define LCD_NIBBLE_MODE_EN for a 4-bit bus (high nibble first on LCD_DATA[7:4]).
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_HIGH_CYC   = 16,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned WAIT_CYC      = 2000,
  parameter int unsigned SLOW_WAIT_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       done_write,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), HOLD_CYC),
                                         max2(WAIT_CYC, SLOW_WAIT_CYC));
  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_WAIT  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_SLOW  = CW'(SLOW_WAIT_CYC - 1);

  lcd_state_t    r_state;
  lcd_state_t    w_state_next;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_zero;
  logic          w_accept;
  logic          w_nib_again;
  logic          r_slow;
  logic          r_en;
  logic          r_rs;
  logic          r_ready;
  logic          r_done;
  logic [7:0]    r_data;

`ifdef LCD_NIBBLE_MODE_EN
  logic          r_second;
  logic [3:0]    r_low;

  assign w_nib_again = !r_second;
`else
  assign w_nib_again = 1'b0;
`endif

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
          w_load       = 1'b1;
          w_load_val   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_zero) begin
          w_state_next = ST_PULSE;
          w_load       = 1'b1;
          w_load_val   = LD_EN;
        end
      end
      ST_PULSE: begin
        if (w_zero) begin
          w_state_next = ST_HOLD;
          w_load       = 1'b1;
          w_load_val   = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (w_nib_again) begin
            w_state_next = ST_SETUP;
            w_load_val   = LD_SETUP;
          end else begin
            w_state_next = ST_WAIT;
            w_load_val   = r_slow ? LD_SLOW : LD_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_zero) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pin registers are driven from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en     <= 1'b0;
      r_rs     <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_slow   <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      r_second <= 1'b0;
      r_low    <= '0;
`endif
    end else begin
      r_en    <= (w_state_next == ST_PULSE);
      r_ready <= (w_state_next == ST_IDLE);
      r_done  <= (r_state == ST_WAIT) && (w_state_next == ST_IDLE);
      if (w_accept) begin
        r_rs   <= rs_in;
        r_slow <= is_slow_cmd(rs_in, data_in);
`ifdef LCD_NIBBLE_MODE_EN
        r_data   <= {data_in[7:4], 4'h0};
        r_low    <= data_in[3:0];
        r_second <= 1'b0;
`else
        r_data <= data_in;
`endif
      end
`ifdef LCD_NIBBLE_MODE_EN
      if ((r_state == ST_HOLD) && w_zero && !r_second) begin
        r_data   <= {r_low, 4'h0};
        r_second <= 1'b1;
      end
`endif
    end
  end

  assign LCD_RW     = 1'b0;
  assign LCD_RS     = r_rs;
  assign LCD_EN     = r_en;
  assign LCD_DATA   = r_data;
  assign ready      = r_ready;
  assign done_write = r_done;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed self-checking bench for lcd_write_engine (8-bit or nibble build).
module tb_lcd_write_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rs_in;
  logic [7:0] data_in;
  logic       ready;
  logic       done_write;
  logic       LCD_RW;
  logic       LCD_RS;
  logic       LCD_EN;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int errors = 0;

`ifdef LCD_NIBBLE_MODE_EN
  localparam bit NIB = 1'b1;
`else
  localparam bit NIB = 1'b0;
`endif

  lcd_write_engine #(
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (4),
    .HOLD_CYC      (2),
    .WAIT_CYC      (8),
    .SLOW_WAIT_CYC (20)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .rs_in      (rs_in),
    .data_in    (data_in),
    .ready      (ready),
    .done_write (done_write),
    .LCD_RW     (LCD_RW),
    .LCD_RS     (LCD_RS),
    .LCD_EN     (LCD_EN),
    .LCD_DATA   (LCD_DATA)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Issue one write and check every pin on each cycle until done_write.
  // With keep_start, start stays high and rs_in/data_in switch to nrs/nd while busy.
  task automatic run_write(input logic rs, input logic [7:0] d, input bit keep_start,
                           input logic nrs, input logic [7:0] nd);
    bit         slow;
    int         done_k;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       exp_en;
    logic [7:0] exp_data;
    slow   = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    done_k = (NIB ? 16 : 8) + (slow ? 20 : 8);
    hi     = NIB ? {d[7:4], 4'h0} : d;
    lo     = {d[3:0], 4'h0};
    start   = 1'b1;
    rs_in   = rs;
    data_in = d;
    @(posedge clk);
    #1;
    if (keep_start) begin
      rs_in   = nrs;
      data_in = nd;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k <= done_k; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      exp_en   = ((k >= 2) && (k < 6)) || (NIB && (k >= 10) && (k < 14));
      exp_data = (NIB && (k >= 8)) ? lo : hi;
      chk("en",    k, {7'd0, LCD_EN},     {7'd0, exp_en});
      chk("data",  k, LCD_DATA,           exp_data);
      chk("rs",    k, {7'd0, LCD_RS},     {7'd0, rs});
      chk("rw",    k, {7'd0, LCD_RW},     8'd0);
      chk("ready", k, {7'd0, ready},      {7'd0, (k == done_k)});
      chk("done",  k, {7'd0, done_write}, {7'd0, (k == done_k)});
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    rs_in   = 1'b0;
    data_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en",    0, {7'd0, LCD_EN},     8'd0);
    chk("rst_rs",    0, {7'd0, LCD_RS},     8'd0);
    chk("rst_data",  0, LCD_DATA,           8'd0);
    chk("rst_done",  0, {7'd0, done_write}, 8'd0);
    chk("rst_ready", 0, {7'd0, ready},      8'd1);
    chk("rst_rw",    0, {7'd0, LCD_RW},     8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("idle_en",    k, {7'd0, LCD_EN},     8'd0);
      chk("idle_data",  k, LCD_DATA,           8'd0);
      chk("idle_rs",    k, {7'd0, LCD_RS},     8'd0);
      chk("idle_ready", k, {7'd0, ready},      8'd1);
      chk("idle_done",  k, {7'd0, done_write}, 8'd0);
      chk("idle_rw",    k, {7'd0, LCD_RW},     8'd0);
    end

    run_write(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    run_write(1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    run_write(1'b0, 8'h38, 1'b0, 1'b0, 8'h00);
    run_write(1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
    run_write(1'b0, 8'h03, 1'b0, 1'b0, 8'h00);
    run_write(1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    run_write(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    run_write(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);

    // start held through the busy period with changed inputs, then back-to-back.
    run_write(1'b1, 8'h41, 1'b1, 1'b0, 8'h38);
    run_write(1'b0, 8'h38, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset while EN is high.
    start   = 1'b1;
    rs_in   = 1'b1;
    data_in = 8'h41;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_en", 3, {7'd0, LCD_EN}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en",    0, {7'd0, LCD_EN},     8'd0);
    chk("mid_rst_ready", 0, {7'd0, ready},      8'd1);
    chk("mid_rst_done",  0, {7'd0, done_write}, 8'd0);
    chk("mid_rst_data",  0, LCD_DATA,           8'd0);
    chk("mid_rst_rs",    0, {7'd0, LCD_RS},     8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      chk("drop_done",  k, {7'd0, done_write}, 8'd0);
      chk("drop_ready", k, {7'd0, ready},      8'd1);
      chk("drop_en",    k, {7'd0, LCD_EN},     8'd0);
    end
    run_write(1'b0, 8'h38, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
